// File: rtl/wave_analyzer.sv
// Hysteresis-based period and peak analyser for a sampled periodic waveform.
// Each rising LO->HI crossing closes a cycle and publishes its length, max and min.
//
// state | meaning
// IDLE  | waiting for a sample at or below LO
// SEEK  | armed below LO, waiting for the first rising event
// MEAS  | locked; counting samples and tracking extremes between rising events
module wave_analyzer #(
  parameter logic [9:0] MID   = 10'd512,
  parameter logic [9:0] HYST  = 10'd16,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       data_in,
  input  logic             data_in_en,
  output logic [CNT_W-1:0] period,
  output logic [9:0]       vmax,
  output logic [9:0]       vmin,
  output logic             result_valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [9:0]       LO      = MID - HYST;
  localparam logic [9:0]       HI      = MID + HYST;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SEEK, MEAS} state_t;

  state_t           state_q;
  logic             below_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       run_max_q, run_min_q;
  logic [CNT_W-1:0] period_q;
  logic [9:0]       vmax_q, vmin_q;
  logic             result_valid_q, timeout_q;

  logic is_low, is_rise;
  logic [9:0] run_max_d, run_min_d;

  always_comb begin
    is_low    = (data_in <= LO);
    is_rise   = below_q && (data_in >= HI);
    run_max_d = (data_in > run_max_q) ? data_in : run_max_q;
    run_min_d = (data_in < run_min_q) ? data_in : run_min_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      below_q        <= 1'b0;
      cnt_q          <= '0;
      run_max_q      <= 10'h000;
      run_min_q      <= 10'h3FF;
      period_q       <= '0;
      vmax_q         <= 10'h000;
      vmin_q         <= 10'h000;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      if (data_in_en) begin
        if (is_low) begin
          below_q <= 1'b1;
        end else if (is_rise) begin
          below_q <= 1'b0;
        end
        case (state_q)
          IDLE: begin
            if (is_low) state_q <= SEEK;
          end
          SEEK: begin
            if (is_rise) begin
              state_q   <= MEAS;
              cnt_q     <= CNT_ONE;
              run_max_q <= data_in;
              run_min_q <= data_in;
            end
          end
          MEAS: begin
            if (is_rise) begin
              // the event sample opens the next cycle, so it is not part of this result
              period_q       <= cnt_q;
              vmax_q         <= run_max_q;
              vmin_q         <= run_min_q;
              result_valid_q <= 1'b1;
              cnt_q          <= CNT_ONE;
              run_max_q      <= data_in;
              run_min_q      <= data_in;
            end else if (cnt_q == CNT_MAX) begin
              timeout_q <= 1'b1;
              state_q   <= IDLE;
              below_q   <= 1'b0;
            end else begin
              cnt_q     <= cnt_q + CNT_ONE;
              run_max_q <= run_max_d;
              run_min_q <= run_min_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period       = period_q;
  assign vmax         = vmax_q;
  assign vmin         = vmin_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;
  assign locked       = (state_q == MEAS);

endmodule
